// File: rtl/sbox_arbiter_if.sv
// Request/response bundle between the two S-box clients, the shared S-box and
// sbox_arbiter. The slave modport is the arbiter's view; master is the opposite side.
interface sbox_arbiter_if;
  logic         data_req_valid;
  logic [127:0] data_req_in;
  logic         data_req_ready;
  logic         data_resp_valid;
  logic [127:0] data_resp_out;
  logic         key_req_valid;
  logic [31:0]  key_req_in;
  logic         key_req_ready;
  logic         key_resp_valid;
  logic [31:0]  key_resp_out;
  logic [7:0]   sb_addr;
  logic [7:0]   sb_data;
  logic         busy;
  logic         grant_key;

  modport slave (
    input  data_req_valid, data_req_in, key_req_valid, key_req_in, sb_data,
    output data_req_ready, data_resp_valid, data_resp_out,
    output key_req_ready, key_resp_valid, key_resp_out,
    output sb_addr, busy, grant_key
  );

  modport master (
    output data_req_valid, data_req_in, key_req_valid, key_req_in, sb_data,
    input  data_req_ready, data_resp_valid, data_resp_out,
    input  key_req_ready, key_resp_valid, key_resp_out,
    input  sb_addr, busy, grant_key
  );
endinterface

// File: rtl/sbox_arbiter.sv
// Time-shares one combinational AES S-box between a 16-byte SubBytes client and a
// 4-byte SubWord client, one byte per cycle. Define ARB_ROUND_ROBIN_EN for round-robin ties.
module sbox_arbiter (
  input logic           clk,
  input logic           rst,
  sbox_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SUB, DONE} state_e;

  state_e       state_q;
  logic [3:0]   cnt_q;
  logic         grant_key_q;
  logic         data_resp_valid_q;
  logic         key_resp_valid_q;
  logic [127:0] data_resp_out_q;
  logic [31:0]  key_resp_out_q;
  logic [127:0] work_q;

  logic tie_key;
  logic win_key;
  logic data_acc;
  logic key_acc;
  logic last_byte;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_key_q;
  assign tie_key = ~last_key_q;
`else
  assign tie_key = 1'b1;
`endif

  assign win_key  = bus.key_req_valid & (~bus.data_req_valid | tie_key);
  assign key_acc  = (state_q == IDLE) & win_key;
  assign data_acc = (state_q == IDLE) & bus.data_req_valid & ~win_key;

  assign bus.key_req_ready  = key_acc;
  assign bus.data_req_ready = data_acc;

  assign last_byte = (cnt_q == (grant_key_q ? 4'd3 : 4'd15));

  // work_q shifts right one byte per SUB cycle, so the next byte is always at [7:0].
  assign bus.sb_addr         = (state_q == SUB) ? work_q[7:0] : 8'h00;
  assign bus.busy            = (state_q != IDLE);
  assign bus.grant_key       = grant_key_q;
  assign bus.data_resp_valid = data_resp_valid_q;
  assign bus.data_resp_out   = data_resp_out_q;
  assign bus.key_resp_valid  = key_resp_valid_q;
  assign bus.key_resp_out    = key_resp_out_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q           <= IDLE;
      cnt_q             <= 4'd0;
      grant_key_q       <= 1'b0;
      data_resp_valid_q <= 1'b0;
      key_resp_valid_q  <= 1'b0;
      data_resp_out_q   <= '0;
      key_resp_out_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_key_q        <= 1'b1;
`endif
    end else begin
      // NOTE: pulse outputs default low here so they stay high for exactly one cycle.
      data_resp_valid_q <= 1'b0;
      key_resp_valid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (data_acc || key_acc) begin
            state_q     <= SUB;
            cnt_q       <= 4'd0;
            grant_key_q <= key_acc;
`ifdef ARB_ROUND_ROBIN_EN
            last_key_q  <= key_acc;
`endif
          end
        end
        SUB: begin
          if (last_byte) begin
            state_q <= DONE;
            cnt_q   <= 4'd0;
            if (grant_key_q) begin
              key_resp_valid_q <= 1'b1;
              key_resp_out_q   <= {bus.sb_data, work_q[31:8]};
            end else begin
              data_resp_valid_q <= 1'b1;
              data_resp_out_q   <= {bus.sb_data, work_q[127:8]};
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: pure datapath, deliberately not reset; it is always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (state_q == IDLE) begin
      if (data_acc) begin
        work_q <= bus.data_req_in;
      end else if (key_acc) begin
        work_q <= {96'h0, bus.key_req_in};
      end
    end else if (state_q == SUB) begin
      if (grant_key_q) begin
        work_q[31:0] <= {bus.sb_data, work_q[31:8]};
      end else begin
        work_q <= {bus.sb_data, work_q[127:8]};
      end
    end
  end

endmodule

// File: tb/tb_sbox_arbiter.sv
// Directed bench for sbox_arbiter: models the shared AES S-box and checks latency,
// results, arbitration, reset abort and back-to-back key requests.
module tb_sbox_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  sbox_arbiter_if bus ();

  sbox_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign bus.sb_data = SBOX[bus.sb_addr];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One request from a single client; checks accept, latency, pulse width and result.
  task automatic run_txn(input bit is_key, input logic [127:0] word,
                         input logic [127:0] exp, input string tag);
    int           n;
    int           first;
    int           pulses;
    int           other;
    bit           acc;
    logic [127:0] got;
    n      = is_key ? 4 : 16;
    first  = -1;
    pulses = 0;
    other  = 0;
    acc    = 1'b0;
    got    = '0;
    @(negedge clk);
    if (is_key) begin
      bus.key_req_in    = word[31:0];
      bus.key_req_valid = 1'b1;
    end else begin
      bus.data_req_in    = word;
      bus.data_req_valid = 1'b1;
    end
    for (int i = 0; i < 4 && !acc; i++) begin
      #1;
      acc = is_key ? bus.key_req_ready : bus.data_req_ready;
      if (!acc) @(negedge clk);
    end
    check({tag, "_accept"}, 128'(acc), 128'(1));
    @(posedge clk);
    #1;
    bus.key_req_valid  = 1'b0;
    bus.data_req_valid = 1'b0;
    bus.data_req_in    = ~word;
    bus.key_req_in     = ~word[31:0];
    for (int i = 1; i <= n + 3; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check({tag, "_grant"}, 128'(bus.grant_key), 128'(is_key));
        check({tag, "_addr0"}, 128'(bus.sb_addr), 128'(word[7:0]));
      end
      if (i == n + 1) check({tag, "_addr_done"}, 128'(bus.sb_addr), 128'(0));
      if (is_key ? bus.key_resp_valid : bus.data_resp_valid) begin
        pulses++;
        if (first < 0) begin
          first = i;
          got   = is_key ? 128'(bus.key_resp_out) : bus.data_resp_out;
        end
      end
      if (is_key ? bus.data_resp_valid : bus.key_resp_valid) other++;
    end
    check({tag, "_latency"}, 128'(first), 128'(n + 1));
    check({tag, "_pulses"}, 128'(pulses), 128'(1));
    check({tag, "_other_valid"}, 128'(other), 128'(0));
    check({tag, "_result"}, got, exp);
  endtask

  initial begin
    bit   g_obs [3];
    bit   gk_obs [3];
    bit   g_exp [3];
    int   gn;
    int   dual;
    bit   pend;
    int   seen;
    int   acc_n;
    int   resp_n;
    int   acc_cyc [4];
    logic [31:0] resp_val [4];

    rst                = 1'b0;
    bus.data_req_valid = 1'b0;
    bus.data_req_in    = '0;
    bus.key_req_valid  = 1'b0;
    bus.key_req_in     = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_grant_key", 128'(bus.grant_key), 128'(0));
    check("rst_data_valid", 128'(bus.data_resp_valid), 128'(0));
    check("rst_key_valid", 128'(bus.key_resp_valid), 128'(0));
    check("rst_data_out", bus.data_resp_out, 128'(0));
    check("rst_key_out", 128'(bus.key_resp_out), 128'(0));
    check("rst_sb_addr", 128'(bus.sb_addr), 128'(0));
    check("rst_readies", 128'({bus.data_req_ready, bus.key_req_ready}), 128'(0));
    rst = 1'b1;

    // Single-client transactions
    run_txn(1'b0, 128'h0, {16{8'h63}}, "data_zero");
    run_txn(1'b1, 128'h00010203, 128'h637c777b, "key_0123");
    check("data_out_held", bus.data_resp_out, {16{8'h63}});
    run_txn(1'b0, 128'h000102030405060708090a0b0c0d0e0f,
            128'h637c777bf26b6fc53001672bfed7ab76, "data_ramp");
    check("key_out_held", 128'(bus.key_resp_out), 128'h637c777b);

    // Both clients valid right after reset: three grants in a row
    do_reset();
    g_exp[0] = RR ? 1'b0 : 1'b1;
    g_exp[1] = 1'b1;
    g_exp[2] = RR ? 1'b0 : 1'b1;
    gn   = 0;
    dual = 0;
    pend = 1'b0;
    for (int i = 0; i < 64 && gn < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.data_req_in    = 128'h0;
        bus.key_req_in     = 32'h00010203;
        bus.data_req_valid = 1'b1;
        bus.key_req_valid  = 1'b1;
      end
      #1;
      if (pend) begin
        gk_obs[gn-1] = bus.grant_key;
        pend         = 1'b0;
      end
      if (bus.data_req_ready && bus.key_req_ready) dual++;
      if (bus.data_req_ready || bus.key_req_ready) begin
        g_obs[gn] = bus.key_req_ready;
        gn++;
        pend = (gn == 1);
      end
    end
    @(posedge clk);
    #1;
    bus.data_req_valid = 1'b0;
    bus.key_req_valid  = 1'b0;
    check("tie_grants", 128'(gn), 128'(3));
    check("tie_first", 128'(g_obs[0]), 128'(g_exp[0]));
    check("tie_first_grant_key", 128'(gk_obs[0]), 128'(g_exp[0]));
    check("tie_second", 128'(g_obs[1]), 128'(g_exp[1]));
    check("tie_third", 128'(g_obs[2]), 128'(g_exp[2]));
    check("tie_dual_ready", 128'(dual), 128'(0));
    repeat (20) @(negedge clk);

    // Reset during SUB cycle 5 aborts the data transaction
    bus.data_req_in    = 128'h53;
    bus.data_req_valid = 1'b1;
    #1;
    check("abort_accept", 128'(bus.data_req_ready), 128'(1));
    @(posedge clk);
    #1;
    bus.data_req_valid = 1'b0;
    bus.data_req_in    = '1;
    seen = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (bus.data_resp_valid || bus.key_resp_valid) seen++;
      if (i == 1) check("abort_addr0", 128'(bus.sb_addr), 128'h53);
    end
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 128'(bus.busy), 128'(0));
    check("abort_data_out", bus.data_resp_out, 128'(0));
    rst = 1'b1;
    bus.data_req_valid = 1'b1;
    #1;
    check("abort_ready_back", 128'(bus.data_req_ready), 128'(1));
    bus.data_req_valid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.data_resp_valid || bus.key_resp_valid) seen++;
    end
    check("abort_no_resp", 128'(seen), 128'(0));

    // Back-to-back key requests with the input word changed after each accept
    acc_n  = 0;
    resp_n = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.key_req_in    = 32'h00010203;
        bus.key_req_valid = 1'b1;
      end
      if (acc_n == 1) bus.key_req_in = 32'h0f0e0d0c;
      if (acc_n == 2) begin
        bus.key_req_in    = 32'hffffffff;
        bus.key_req_valid = 1'b0;
      end
      #1;
      if (bus.key_req_ready && acc_n < 4) begin
        acc_cyc[acc_n] = i;
        acc_n++;
      end
      if (bus.key_resp_valid && resp_n < 4) begin
        resp_val[resp_n] = bus.key_resp_out;
        resp_n++;
      end
    end
    check("b2b_accepts", 128'(acc_n), 128'(2));
    check("b2b_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'(6));
    check("b2b_responses", 128'(resp_n), 128'(2));
    check("b2b_first_result", 128'(resp_val[0]), 128'h637c777b);
    check("b2b_second_result", 128'(resp_val[1]), 128'h76abd7fe);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
